// File: rtl/muldiv_prenorm.sv
// FP mul/div pre-stage: classify, resolve specials, normalise subnormals (divide rules under MULDIV_PRE_DIV_EN).
// Latency 1 cycle, or 1+s for a subnormal needing s shifts; one op in flight, holds result until out_ready.
module muldiv_prenorm #(
  parameter int NUM_BITS   = 16,
  parameter int EXP_WIDTH  = 5,
  parameter int MANT_WIDTH = 10,
  parameter int BIAS       = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        op,
  input  logic [NUM_BITS-1:0]         a_src,
  input  logic [NUM_BITS-1:0]         b_src,
  input  logic                        a_zero,
  input  logic                        a_inf,
  input  logic                        a_subN,
  input  logic                        a_Norm,
  input  logic                        a_QNan,
  input  logic                        a_SNan,
  input  logic                        b_zero,
  input  logic                        b_inf,
  input  logic                        b_subN,
  input  logic                        b_Norm,
  input  logic                        b_QNan,
  input  logic                        b_SNan,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        op_out,
  output logic [MANT_WIDTH:0]         mant_a,
  output logic [MANT_WIDTH:0]         mant_b,
  output logic signed [EXP_WIDTH+1:0] exp_a,
  output logic signed [EXP_WIDTH+1:0] exp_b,
  output logic                        sign,
  output logic                        arithmetic,
  output logic [NUM_BITS-1:0]         direct_result,
  output logic                        zero,
  output logic                        inf,
  output logic                        qnan,
  output logic                        snan
);
  localparam int EW = EXP_WIDTH + 2;
  localparam int MW = MANT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

  typedef struct packed {
    logic                op;
    logic [MW-1:0]       mant_a;
    logic [MW-1:0]       mant_b;
    logic [EW-1:0]       exp_a;
    logic [EW-1:0]       exp_b;
    logic                sign;
    logic                arithmetic;
    logic [NUM_BITS-1:0] direct;
    logic                zero;
    logic                inf;
    logic                qnan;
    logic                snan;
  } res_t;

  state_t state_q, state_d;
  res_t   res_q, res_d, acc;
  logic   out_valid_q, out_valid_d;
  logic   is_div;
  logic   res_sign;

`ifdef MULDIV_PRE_DIV_EN
  assign is_div = op;
`else
  logic unused_op;
  assign unused_op = op;
  assign is_div    = 1'b0;
`endif

  assign res_sign = a_src[NUM_BITS-1] ^ b_src[NUM_BITS-1];

  // Result captured on accept; mant/exp are filled in even for special cases since they are don't-care there.
  always_comb begin
    acc            = '0;
    acc.op         = is_div;
    acc.sign       = res_sign;
    acc.mant_a     = {a_Norm, a_src[MANT_WIDTH-1:0]};
    acc.mant_b     = {b_Norm, b_src[MANT_WIDTH-1:0]};
    acc.exp_a      = a_Norm ? EW'(a_src[NUM_BITS-2:MANT_WIDTH]) - EW'(BIAS) : EW'(1) - EW'(BIAS);
    acc.exp_b      = b_Norm ? EW'(b_src[NUM_BITS-2:MANT_WIDTH]) - EW'(BIAS) : EW'(1) - EW'(BIAS);
    if (a_SNan || b_SNan) begin
      acc.snan   = 1'b1;
      acc.direct = a_SNan ? a_src : b_src;
    end else if (a_QNan || b_QNan) begin
      acc.qnan   = 1'b1;
      acc.direct = a_QNan ? a_src : b_src;
    end else if (!is_div && (a_inf || b_inf)) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        acc.qnan   = 1'b1;
        acc.direct = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
      end else begin
        acc.inf    = 1'b1;
        acc.direct = {res_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      end
`ifdef MULDIV_PRE_DIV_EN
    end else if (is_div && ((a_inf && b_inf) || (a_zero && b_zero))) begin
      acc.qnan   = 1'b1;
      acc.direct = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    end else if (is_div && (a_inf || b_zero)) begin
      acc.inf    = 1'b1;
      acc.direct = {res_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (is_div && (b_inf || a_zero)) begin
      acc.zero   = 1'b1;
      acc.direct = {res_sign, {(NUM_BITS-1){1'b0}}};
`endif
    end else if (!is_div && (a_zero || b_zero || (a_subN && b_subN))) begin
      acc.zero   = 1'b1;
      acc.direct = {res_sign, {(NUM_BITS-1){1'b0}}};
    end else begin
      acc.arithmetic = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          res_d = acc;
          if (acc.arithmetic && (a_subN || b_subN)) begin
            state_d = NORM;
          end else begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
          end
        end
      end
      NORM: begin
        if (!res_q.mant_a[MW-1]) begin
          res_d.mant_a = res_q.mant_a << 1;
          res_d.exp_a  = res_q.exp_a - EW'(1);
        end
        if (!res_q.mant_b[MW-1]) begin
          res_d.mant_b = res_q.mant_b << 1;
          res_d.exp_b  = res_q.exp_b - EW'(1);
        end
        // Look at the post-shift values so the final shift and out_valid land on the same edge.
        if (res_d.mant_a[MW-1] && res_d.mant_b[MW-1]) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = (state_q == IDLE) && !out_valid_q;
  assign out_valid     = out_valid_q;
  assign op_out        = res_q.op;
  assign mant_a        = res_q.mant_a;
  assign mant_b        = res_q.mant_b;
  assign exp_a         = $signed(res_q.exp_a);
  assign exp_b         = $signed(res_q.exp_b);
  assign sign          = res_q.sign;
  assign arithmetic    = res_q.arithmetic;
  assign direct_result = res_q.direct;
  assign zero          = res_q.zero;
  assign inf           = res_q.inf;
  assign qnan          = res_q.qnan;
  assign snan          = res_q.snan;
endmodule

// File: tb/tb_muldiv_prenorm.sv
// Self-checking bench for muldiv_prenorm (fp16): vector table with scoreboard plus backpressure and reset-in-NORM sequences.
module tb_muldiv_prenorm;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, op, out_valid, out_ready, op_out;
  logic [15:0] a_src, b_src, direct_result;
  logic a_zero, a_inf, a_subN, a_Norm, a_QNan, a_SNan;
  logic b_zero, b_inf, b_subN, b_Norm, b_QNan, b_SNan;
  logic [10:0] mant_a, mant_b;
  logic signed [6:0] exp_a, exp_b;
  logic sign, arithmetic, zero, inf, qnan, snan;

  int n_vec = 0;
  int n_bad = 0;

`ifdef MULDIV_PRE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic        op;
    logic [15:0] a, b;
    logic        arith, sgn, z, i, q, s;
    logic [15:0] direct;
    int          ma, mb, ea, eb, lat;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];

  muldiv_prenorm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_src(a_src), .b_src(b_src),
    .a_zero(a_zero), .a_inf(a_inf), .a_subN(a_subN), .a_Norm(a_Norm), .a_QNan(a_QNan), .a_SNan(a_SNan),
    .b_zero(b_zero), .b_inf(b_inf), .b_subN(b_subN), .b_Norm(b_Norm), .b_QNan(b_QNan), .b_SNan(b_SNan),
    .out_valid(out_valid), .out_ready(out_ready), .op_out(op_out),
    .mant_a(mant_a), .mant_b(mant_b), .exp_a(exp_a), .exp_b(exp_b),
    .sign(sign), .arithmetic(arithmetic), .direct_result(direct_result),
    .zero(zero), .inf(inf), .qnan(qnan), .snan(snan)
  );

  always #5 clk = ~clk;

  // {zero, inf, subN, Norm, QNan, SNan}
  function automatic logic [5:0] cls(input logic [15:0] x);
    logic [4:0] e;
    logic [9:0] m;
    e = x[14:10];
    m = x[9:0];
    if (e == 5'd0) return (m == 10'd0) ? 6'b100000 : 6'b001000;
    if (e == 5'h1f) return (m == 10'd0) ? 6'b010000 : (m[9] ? 6'b000010 : 6'b000001);
    return 6'b000100;
  endfunction

  function automatic vec_t mk(input logic o, input logic [15:0] a, input logic [15:0] b,
                              input logic ar, input logic sg, input logic z, input logic i,
                              input logic q, input logic s, input logic [15:0] d,
                              input int ma, input int mb, input int ea, input int eb, input int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.arith = ar; v.sgn = sg;
    v.z = z; v.i = i; v.q = q; v.s = s; v.direct = d;
    v.ma = ma; v.mb = mb; v.ea = ea; v.eb = eb; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive(input logic o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op = o;
    a_src = a;
    b_src = b;
    {a_zero, a_inf, a_subN, a_Norm, a_QNan, a_SNan} = cls(a);
    {b_zero, b_inf, b_subN, b_Norm, b_QNan, b_SNan} = cls(b);
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_out(input vec_t e, input int lat);
    chk("latency", lat, e.lat);
    chk("arithmetic", int'(arithmetic), int'(e.arith));
    chk("sign", int'(sign), int'(e.sgn));
    chk("flags_zinq", int'({zero, inf, qnan, snan}), int'({e.z, e.i, e.q, e.s}));
    chk("direct_result", int'(direct_result), int'(e.direct));
    chk("op_out", int'(op_out), int'(e.op & DIV_EN));
    if (e.arith) begin
      chk("mant_a", int'(mant_a), e.ma);
      chk("mant_b", int'(mant_b), e.mb);
      chk("exp_a", int'(exp_a), e.ea);
      chk("exp_b", int'(exp_b), e.eb);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int lat;
    drive(v.op, v.a, v.b);
    sb.push_back(v);
    chk("busy_in_ready", int'(in_ready), 0);
    wait_out(lat);
    e = sb.pop_front();
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    else check_out(e, lat);
    @(posedge clk);
    #1;
    chk("hold_exit_valid", int'(out_valid), 0);
    chk("hold_exit_ready", int'(in_ready), 1);
  endtask

  initial begin
    vec_t e;
    int lat;

    vecs[0]  = mk(0, 16'h4200, 16'h4000, 1, 0, 0, 0, 0, 0, 16'h0000, 'h600, 'h400, 1, 1, 1);
    vecs[1]  = mk(0, 16'h0001, 16'h3C00, 1, 0, 0, 0, 0, 0, 16'h0000, 'h400, 'h400, -24, 0, 11);
    vecs[2]  = mk(0, 16'h7C01, 16'h7E00, 0, 0, 0, 0, 0, 1, 16'h7C01, 0, 0, 0, 0, 1);
    vecs[3]  = mk(0, 16'h7C00, 16'h8000, 0, 1, 0, 0, 1, 0, 16'h7E00, 0, 0, 0, 0, 1);
    vecs[4]  = mk(0, 16'hC000, 16'h7C00, 0, 1, 0, 1, 0, 0, 16'hFC00, 0, 0, 0, 0, 1);
    vecs[5]  = mk(0, 16'h0200, 16'h8001, 0, 1, 1, 0, 0, 0, 16'h8000, 0, 0, 0, 0, 1);
    vecs[6]  = mk(0, 16'h3C00, 16'h8000, 0, 1, 1, 0, 0, 0, 16'h8000, 0, 0, 0, 0, 1);
    vecs[7]  = mk(0, 16'h7E00, 16'h7D00, 0, 0, 0, 0, 0, 1, 16'h7D00, 0, 0, 0, 0, 1);
    vecs[8]  = mk(0, 16'h7E00, 16'h3C00, 0, 0, 0, 0, 1, 0, 16'h7E00, 0, 0, 0, 0, 1);
    vecs[9]  = mk(0, 16'h0200, 16'hBC00, 1, 1, 0, 0, 0, 0, 16'h0000, 'h400, 'h400, -15, 0, 2);
    vecs[10] = mk(0, 16'h3555, 16'h0033, 1, 0, 0, 0, 0, 0, 16'h0000, 'h555, 'h660, -2, -19, 6);
`ifdef MULDIV_PRE_DIV_EN
    vecs[11] = mk(1, 16'h3C00, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h7C00, 0, 0, 0, 0, 1);
    vecs[12] = mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 16'h7E00, 0, 0, 0, 0, 1);
    vecs[13] = mk(1, 16'h3C00, 16'h7C00, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, 16'h0001, 16'h0200, 1, 0, 0, 0, 0, 0, 16'h0000, 'h400, 'h400, -24, -15, 11);
    vecs[15] = mk(1, 16'h7C00, 16'h7C00, 0, 0, 0, 0, 1, 0, 16'h7E00, 0, 0, 0, 0, 1);
`else
    // Divide requests fall back to multiply rules when divide support is compiled out.
    vecs[11] = mk(1, 16'h3C00, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    vecs[12] = mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    vecs[13] = mk(1, 16'h3C00, 16'h7C00, 0, 0, 0, 1, 0, 0, 16'h7C00, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, 16'h0001, 16'h0200, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    vecs[15] = mk(1, 16'h7C00, 16'h7C00, 0, 0, 0, 1, 0, 0, 16'h7C00, 0, 0, 0, 0, 1);
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 1'b0;
    a_src = '0;
    b_src = '0;
    {a_zero, a_inf, a_subN, a_Norm, a_QNan, a_SNan} = '0;
    {b_zero, b_inf, b_subN, b_Norm, b_QNan, b_SNan} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_direct", int'(direct_result), 0);
    chk("rst_flags", int'({arithmetic, zero, inf, qnan, snan, sign, op_out}), 0);
    chk("rst_mant", int'({mant_a, mant_b}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 16; v++) run_vec(vecs[v]);

    // Backpressure: result must hold steady with in_ready low until out_ready returns.
    out_ready = 1'b0;
    drive(vecs[0].op, vecs[0].a, vecs[0].b);
    sb.push_back(vecs[0]);
    wait_out(lat);
    e = sb.pop_front();
    if (!out_valid) chk("bp_out_valid_timeout", 0, 1);
    else check_out(e, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_mant_a", int'(mant_a), 'h600);
      chk("bp_exp_b", int'(exp_b), 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);

    // Reset while normalising discards the operation.
    drive(vecs[1].op, vecs[1].a, vecs[1].b);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("norm_rst_out_valid", int'(out_valid), 0);
    chk("norm_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[10]);
    run_vec(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
